fifo_flags: RTL and testbench
=============================

# fifo_flags

Parametrised synchronous FIFO that succeeds the basic fifo. It adds arbitrary (non-power-of-two) depth, an occupancy count, programmable almost-full/almost-empty thresholds, and defined handling of overflow and underflow. It sits between producer and consumer stages on the single design clock. It is a drop-in where a show-ahead FIFO with occupancy visibility is needed.

## Interface
- `WIDTH`, 8, data word width in bits (≥1)
- `DEPTH`, 8, number of entries (≥2, any integer, need not be a power of two)
- `CNTWID`, $clog2(DEPTH+1), width of the occupancy count
- `AF_LVL`, DEPTH-1, almost_full asserts when count ≥ AF_LVL (1..DEPTH)
- `AE_LVL`, 1, almost_empty asserts when count ≤ AE_LVL (0..DEPTH-1)

Ports:
- `clk` input 1: sole clock, rising edge
- `rst` input 1: reset, asynchronous assert, active-low (0 = reset); deassertion is synchronised externally
- `push` input 1: write request
- `pop` input 1: read request
- `data_in` input WIDTH: write data
- `data_out` output WIDTH: head entry (show-ahead)
- `full` output 1: count == DEPTH
- `empty` output 1: count == 0
- `almost_full` output 1: count ≥ AF_LVL
- `almost_empty` output 1: count ≤ AE_LVL
- `count` output CNTWID: current occupancy
- `overflow` output 1: push rejected (see Configuration)
- `underflow` output 1: pop rejected (see Configuration)

## Operation
- State: `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, range 0..DEPTH-1. Both wrap from DEPTH-1 to 0 by explicit compare, not by modulo-2^n. Also `count` (CNTWID bits) and the storage array.
- Acceptance:
  - push_ok = push & (!full | pop)
  - pop_ok = pop & !empty
- push_ok: entry[wr_ptr] ← data_in; wr_ptr advances with wrap.
- pop_ok: rd_ptr advances with wrap.
- count_next = count + push_ok − pop_ok. It never exceeds DEPTH and never goes below 0.
- Flags are decoded combinationally from registered `count` only. No flag depends on push or pop in the same cycle.
- `data_out` = entry[rd_ptr], combinational from state.
  - When empty, data_out holds the last-popped/stale value and is don't-care.
  - After reset it reads 0, because storage clears on reset.
- Full with push & pop: both are accepted. The write lands in the slot being vacated. data_out shows the old head in that cycle (read-before-write).
- Empty with push & pop: the push is accepted and the pop is rejected. There is no bypass, so the new word appears on data_out next cycle.
- Rejected push: storage and wr_ptr are unchanged.
- Rejected pop: rd_ptr is unchanged.
- Reset (rst = 0) at any time, including mid-burst, immediately clears the following:
  - pointers = 0, count = 0, storage = 0
  - overflow = underflow = 0
  - Resulting outputs: empty = 1, full = 0, almost_empty = 1 (AE_LVL ≥ 0), almost_full = 0, data_out = 0.

## Timing
- All state updates on the rising edge of clk when rst = 1.
- Write-to-read latency: 1 cycle. A word pushed at edge N appears on data_out after edge N when the FIFO was empty.
- count and all flags reflect the edge-N operations immediately after edge N. There is no extra pipeline stage.
- Pop takes effect at the edge. The consumer samples data_out in the same cycle it asserts pop.
- No handshake stall. push and pop are single-cycle requests evaluated every cycle.

## Configuration
- `FIFO_STICKY_ERR_EN` defined:
  - overflow sets on any cycle with push & !push_ok; underflow sets on pop & empty.
  - Both stay set until reset.
- Not defined:
  - overflow and underflow are single-cycle pulses, registered one cycle after the offending request and cleared the following cycle unless repeated.
- Storage and pointer behaviour are identical in both builds.

## Test plan
- Reset, then DEPTH=8, WIDTH=8: push 0x01..0x08 on 8 consecutive cycles → full = 1 and count = 8 after the 8th edge; almost_full = 1 from count 7; 8 pops return 0x01..0x08 in order; empty = 1 at end.
- DEPTH=5: push 3, pop 3, repeated 4 times with data 0x10+i → pointers wrap past 4 correctly; output order matches input; count never exceeds 3.
- Full FIFO (DEPTH=8), push 0xAA & pop together → data_out shows old head that cycle; count stays 8; 0xAA is read out last after 7 more pops.
- Empty FIFO, pop alone → underflow asserts; count stays 0. Push 0x55 & pop together → count = 1, data_out = 0x55 next cycle.
- Full FIFO, push 0x77 alone → overflow asserts and word is dropped. With FIFO_STICKY_ERR_EN, overflow stays 1 over 10 idle cycles; without it, overflow returns to 0 after 1 cycle.
- Push 4 words, assert rst = 0 mid-cycle between edges → count = 0, empty = 1, data_out = 0, flags cleared without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_flags.sv
// Show-ahead synchronous FIFO with arbitrary depth, occupancy count, almost flags and
// overflow/underflow reporting. Define FIFO_STICKY_ERR_EN to hold error flags until reset.
module fifo_flags #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNTWID = $clog2(DEPTH + 1),
  parameter int unsigned AF_LVL = DEPTH - 1,
  parameter int unsigned AE_LVL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNTWID-1:0] count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTWID-1:0] count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              push_ok, pop_ok, push_rej, pop_rej;

  // Flags come from registered count only, never from this cycle's requests.
  assign full         = (count_q == CNTWID'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNTWID'(AF_LVL));
  assign almost_empty = (count_q <= CNTWID'(AE_LVL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign data_out     = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push & (~full | pop);
    pop_ok   = pop & ~empty;
    push_rej = push & ~push_ok;
    pop_rej  = pop & empty;

    wr_ptr_d = wr_ptr_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end

    rd_ptr_d = rd_ptr_q;
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end

    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

`ifdef FIFO_STICKY_ERR_EN
    overflow_d  = overflow_q | push_rej;
    underflow_d = underflow_q | pop_rej;
`else
    overflow_d  = push_rej;
    underflow_d = pop_rej;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // When full with push and pop, the write lands in the slot being vacated; data_out
  // still shows the old head until the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_fifo_flags.sv
// Randomized and directed bench for fifo_flags: a DEPTH=8 and a DEPTH=5 instance share
// stimulus and are each checked every cycle against a queue-based model.
module tb_fifo_flags;

  localparam int D8  = 8;
  localparam int D5  = 5;
  localparam int AF5 = 3;
  localparam int AE5 = 2;
`ifdef FIFO_STICKY_ERR_EN
  localparam bit Sticky = 1'b1;
`else
  localparam bit Sticky = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] data_in = '0;

  logic [7:0] do_a, do_b;
  logic       full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic       full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [3:0] count_a;
  logic [2:0] count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_flags #(.WIDTH(8), .DEPTH(D8)) dut_a (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .data_in(data_in), .data_out(do_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
    .count(count_a), .overflow(ovf_a), .underflow(unf_a)
  );

  fifo_flags #(.WIDTH(8), .DEPTH(D5), .AF_LVL(AF5), .AE_LVL(AE5)) dut_b (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .data_in(data_in), .data_out(do_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .count(count_b), .overflow(ovf_b), .underflow(unf_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue contents, expected error flags, "nothing pushed since reset".
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       m_ovf_a = 1'b0, m_unf_a = 1'b0, m_ovf_b = 1'b0, m_unf_b = 1'b0;
  bit         clean_a = 1'b1, clean_b = 1'b1;

  always @(posedge clk) begin
    logic       p, q, bad_p, bad_q, pok, qok;
    logic [7:0] d;
    p = push;
    q = pop;
    d = data_in;
    if (!rst) begin
      qa.delete();
      qb.delete();
      m_ovf_a = 1'b0; m_unf_a = 1'b0; m_ovf_b = 1'b0; m_unf_b = 1'b0;
      clean_a = 1'b1; clean_b = 1'b1;
    end else begin
      bad_p = p && !q && (qa.size() == D8);
      bad_q = q && (qa.size() == 0);
      pok   = p && ((qa.size() < D8) || q);
      qok   = q && (qa.size() > 0);
      if (qok) void'(qa.pop_front());
      if (pok) begin qa.push_back(d); clean_a = 1'b0; end
      m_ovf_a = (Sticky && m_ovf_a) || bad_p;
      m_unf_a = (Sticky && m_unf_a) || bad_q;

      bad_p = p && !q && (qb.size() == D5);
      bad_q = q && (qb.size() == 0);
      pok   = p && ((qb.size() < D5) || q);
      qok   = q && (qb.size() > 0);
      if (qok) void'(qb.pop_front());
      if (pok) begin qb.push_back(d); clean_b = 1'b0; end
      m_ovf_b = (Sticky && m_ovf_b) || bad_p;
      m_unf_b = (Sticky && m_unf_b) || bad_q;
    end
    #1;
    chk("a_count", count_a, qa.size());
    chk("a_full", full_a, qa.size() == D8);
    chk("a_empty", empty_a, qa.size() == 0);
    chk("a_almost_full", af_a, qa.size() >= D8 - 1);
    chk("a_almost_empty", ae_a, qa.size() <= 1);
    chk("a_overflow", ovf_a, m_ovf_a);
    chk("a_underflow", unf_a, m_unf_a);
    if (qa.size() > 0) chk("a_data_out", do_a, qa[0]);
    else if (clean_a) chk("a_data_out_reset", do_a, 0);
    chk("b_count", count_b, qb.size());
    chk("b_full", full_b, qb.size() == D5);
    chk("b_empty", empty_b, qb.size() == 0);
    chk("b_almost_full", af_b, qb.size() >= AF5);
    chk("b_almost_empty", ae_b, qb.size() <= AE5);
    chk("b_overflow", ovf_b, m_ovf_b);
    chk("b_underflow", unf_b, m_unf_b);
    if (qb.size() > 0) chk("b_data_out", do_b, qb[0]);
    else if (clean_b) chk("b_data_out_reset", do_b, 0);
  end

  task automatic step(input logic p, input logic q, input logic [7:0] d);
    @(negedge clk);
    push = p;
    pop = q;
    data_in = d;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    @(posedge clk);
    #2;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int pp, pq;
    do_reset();
    chk("rst_count", count_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_almost_empty", ae_a, 1);
    chk("rst_almost_full", af_a, 0);
    chk("rst_data_out", do_a, 0);

    // Fill to full, then drain in order.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 8'(i));
      if (i == 6) chk("af_at6", af_a, 0);
      if (i == 7) chk("af_at7", af_a, 1);
    end
    chk("fill_full", full_a, 1);
    chk("fill_count", count_a, 8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", do_a, i);
      step(1'b0, 1'b1, 8'h00);
    end
    chk("drain_empty", empty_a, 1);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    @(negedge clk);
    push = 1'b1; pop = 1'b1; data_in = 8'hAA;
    #1;
    chk("full_pp_old_head", do_a, 8'h20);
    @(posedge clk);
    #2;
    chk("full_pp_count", count_a, 8);
    chk("full_pp_next_head", do_a, 8'h21);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00);
    chk("full_pp_aa_last", do_a, 8'hAA);
    chk("full_pp_aa_count", count_a, 1);
    step(1'b0, 1'b1, 8'h00);

    // Empty: pop alone, then push and pop together.
    step(1'b0, 1'b1, 8'h00);
    chk("empty_pop_underflow", unf_a, 1);
    chk("empty_pop_count", count_a, 0);
    step(1'b1, 1'b1, 8'h55);
    chk("empty_pp_count", count_a, 1);
    chk("empty_pp_data", do_a, 8'h55);
    step(1'b0, 1'b1, 8'h00);

    // Overflow on full and its persistence.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    step(1'b1, 1'b0, 8'h77);
    chk("ovf_set", ovf_a, 1);
    chk("ovf_count", count_a, 8);
    step(1'b0, 1'b0, 8'h00);
    chk("ovf_after1", ovf_a, Sticky);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00);
    chk("ovf_after10", ovf_a, Sticky);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain", do_a, 8'h30 + i);
      step(1'b0, 1'b1, 8'h00);
    end
    chk("ovf_dropped", empty_a, 1);

    // DEPTH=5 pointer wrap.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 8'(8'h10 + r * 3 + j));
      chk("wrap_count", count_b, 3);
      for (int j = 0; j < 3; j++) begin
        chk("wrap_order", do_b, 8'h10 + r * 3 + j);
        step(1'b0, 1'b1, 8'h00);
      end
    end

    // Asynchronous reset between edges.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    push = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("async_count", count_a, 0);
    chk("async_empty", empty_a, 1);
    chk("async_data_out", do_a, 0);
    chk("async_almost_empty", ae_a, 1);
    chk("async_overflow", ovf_a, 0);
    chk("async_b_count", count_b, 0);
    @(posedge clk);
    #2;
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic with shifting bias and occasional resets.
    for (int n = 0; n < 4000; n++) begin
      case ((n / 500) % 3)
        0:       begin pp = 80; pq = 30; end
        1:       begin pp = 30; pq = 80; end
        default: begin pp = 60; pq = 60; end
      endcase
      @(negedge clk);
      rst = ($urandom_range(0, 299) != 0);
      push = ($urandom_range(0, 99) < pp);
      pop = ($urandom_range(0, 99) < pq);
      data_in = 8'($urandom);
    end
    @(negedge clk);
    rst = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
